// File: rtl/jtag_scan_sequencer.sv
// Two-requester JTAG scan sequencer: shifts TMS/TDI bits at a divided TCK and captures TDO.
// Define JTAG_SEQ_RR_EN for round-robin arbitration; default build gives req0 fixed priority.
module jtag_scan_sequencer #(
    parameter int HALF_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  cmd0,
    input  logic [1:0]  cmd1,
    input  logic [5:0]  nbits0,
    input  logic [5:0]  nbits1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);
    localparam int PW = (HALF_DIV > 1) ? $clog2(2 * HALF_DIV) : 1;
    localparam logic [PW-1:0] PH_HIGH = PW'(HALF_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * HALF_DIV - 1);

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_TMS   = 2'd1;
    localparam logic [1:0] CMD_SCAN  = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [1:0]    cmd_r, cmd_nx;
    logic [5:0]    n_r, n_nx;
    logic [31:0]   wdata_r, wdata_nx;
    logic [5:0]    bit_r, bit_nx;
    logic [PW-1:0] ph_r, ph_nx, ph_inc;
    logic          owner_r, owner_nx;
    logic [31:0]   shadow_r, shadow_nx, shadow_cap, rdata_nx;
    logic          gnt0_nx, gnt1_nx, done0_nx, done1_nx;
    logic          tck_nx, tms_nx, tdi_nx;
    logic          win, do_grant;
    logic [1:0]    sel_cmd;
    logic [5:0]    sel_n;
    logic [31:0]   sel_wdata;
`ifdef JTAG_SEQ_RR_EN
    logic          rr_r, rr_nx;
`endif

    // Effective bit count: RESET is always 6 bits, others saturate at 32.
    function automatic logic [5:0] sat_nbits(input logic [1:0] c, input logic [5:0] nb);
        if (c == CMD_RESET) return 6'd6;
        if (nb > 6'd32) return 6'd32;
        return nb;
    endfunction

    function automatic logic bit_tms(input logic [1:0] c, input logic [31:0] w,
                                     input logic [5:0] i, input logic [5:0] n);
        if (i >= n) return 1'b0;
        case (c)
            CMD_RESET: return i < 6'd5;
            CMD_TMS:   return w[i[4:0]];
            CMD_SCAN:  return 1'b0;
            default:   return i == (n - 6'd1);
        endcase
    endfunction

    function automatic logic bit_tdi(input logic [1:0] c, input logic [31:0] w,
                                     input logic [5:0] i, input logic [5:0] n);
        if (i >= n || !c[1]) return 1'b0;
        return w[i[4:0]];
    endfunction

`ifdef JTAG_SEQ_RR_EN
    assign win = (req0 && req1) ? rr_r : !req0;
`else
    assign win = !req0;
`endif

    assign sel_cmd   = win ? cmd1 : cmd0;
    assign sel_wdata = win ? wdata1 : wdata0;
    assign sel_n     = sat_nbits(sel_cmd, win ? nbits1 : nbits0);
    assign do_grant  = enable && (req0 || req1) && (state != RUN);
    assign ph_inc    = ph_r + PW'(1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx   = state;
        cmd_nx     = cmd_r;
        n_nx       = n_r;
        wdata_nx   = wdata_r;
        bit_nx     = bit_r;
        ph_nx      = ph_r;
        owner_nx   = owner_r;
        shadow_nx  = shadow_r;
        shadow_cap = shadow_r;
        rdata_nx   = rdata;
        gnt0_nx    = 1'b0;
        gnt1_nx    = 1'b0;
        done0_nx   = 1'b0;
        done1_nx   = 1'b0;
        tck_nx     = tck;
        tms_nx     = tms;
        tdi_nx     = tdi;
`ifdef JTAG_SEQ_RR_EN
        rr_nx      = rr_r;
`endif
        case (state)
            RUN: begin
                if (ph_r == PH_HIGH && cmd_r[1])
                    shadow_cap[bit_r[4:0]] = tdo;
                shadow_nx = shadow_cap;
                if (n_r == 6'd0 || (ph_r == PH_LAST && bit_r == n_r - 6'd1)) begin
                    state_nx = DONE;
                    tck_nx   = 1'b0;
                    tms_nx   = 1'b0;
                    tdi_nx   = 1'b0;
                    rdata_nx = shadow_cap;
                    done0_nx = !owner_r;
                    done1_nx = owner_r;
                end else if (ph_r == PH_LAST) begin
                    bit_nx = bit_r + 6'd1;
                    ph_nx  = '0;
                    tck_nx = 1'b0;
                    tms_nx = bit_tms(cmd_r, wdata_r, bit_r + 6'd1, n_r);
                    tdi_nx = bit_tdi(cmd_r, wdata_r, bit_r + 6'd1, n_r);
                end else begin
                    ph_nx = ph_inc;
                    if (ph_inc == PH_HIGH) tck_nx = 1'b1;
                end
            end
            default: begin
                // DONE can grant directly so the next command starts right after done.
                state_nx = IDLE;
                if (do_grant) begin
                    state_nx  = RUN;
                    cmd_nx    = sel_cmd;
                    n_nx      = sel_n;
                    wdata_nx  = sel_wdata;
                    bit_nx    = '0;
                    ph_nx     = '0;
                    owner_nx  = win;
                    shadow_nx = '0;
                    gnt0_nx   = !win;
                    gnt1_nx   = win;
                    tck_nx    = 1'b0;
                    tms_nx    = bit_tms(sel_cmd, sel_wdata, 6'd0, sel_n);
                    tdi_nx    = bit_tdi(sel_cmd, sel_wdata, 6'd0, sel_n);
`ifdef JTAG_SEQ_RR_EN
                    rr_nx     = !win;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        cmd_r    <= cmd_nx;
        n_r      <= n_nx;
        wdata_r  <= wdata_nx;
        shadow_r <= shadow_nx;
        if (!rst_n) begin
            state   <= IDLE;
            bit_r   <= '0;
            ph_r    <= '0;
            owner_r <= 1'b0;
            rdata   <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            tck     <= 1'b0;
            tms     <= 1'b0;
            tdi     <= 1'b0;
`ifdef JTAG_SEQ_RR_EN
            rr_r    <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            bit_r   <= bit_nx;
            ph_r    <= ph_nx;
            owner_r <= owner_nx;
            rdata   <= rdata_nx;
            gnt0    <= gnt0_nx;
            gnt1    <= gnt1_nx;
            done0   <= done0_nx;
            done1   <= done1_nx;
            tck     <= tck_nx;
            tms     <= tms_nx;
            tdi     <= tdi_nx;
`ifdef JTAG_SEQ_RR_EN
            rr_r    <= rr_nx;
`endif
        end
    end
endmodule

// File: doc/jtag_scan_sequencer.md
JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 SHALL have parameter HALF_DIV, default 4: TCK half-period in clk cycles; legal values are 1 or greater.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: when low, no new grant is issued.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: command request from requester 0/1.
REQ-006 SHALL have ports cmd0/cmd1, input, 2 bits each: 0=RESET, 1=TMS_SEQ, 2=SCAN, 3=SCAN_FLIP_TMS.
REQ-007 SHALL have ports nbits0/nbits1, input, 6 bits each: bit count, legal range 1..32.
REQ-008 SHALL have ports wdata0/wdata1, input, 32 bits each: TMS or TDI bits, shifted LSB first.
REQ-009 SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle pulse marking the cycle in which that requester's payload is latched.
REQ-010 SHALL have ports done0/done1, output, 1 bit each: one-cycle pulse that qualifies rdata.
REQ-011 SHALL have port rdata, output, 32 bits: captured TDO bits, LSB first, with unused upper bits 0.
REQ-012 SHALL have port busy, output, 1 bit: high from grant through done.
REQ-013 SHALL have ports tck, tms and tdi, output, 1 bit each, all registered: JTAG pins.
REQ-014 SHALL have port tdo, input, 1 bit: JTAG data return.

Function
REQ-015 SHALL implement states IDLE -> RUN -> DONE -> IDLE.
REQ-016 SHALL, in IDLE with enable=1 and at least one req high, latch the winner's cmd/nbits/wdata, pulse its gnt next cycle, and enter RUN.
REQ-017 SHALL, for each bit, drive a low phase (tck=0, HALF_DIV cycles; tms/tdi updated on the first low-phase cycle) followed by a high phase (tck=1, HALF_DIV cycles).
REQ-018 SHALL present the bit 0 tms/tdi values in the gnt cycle, and that cycle SHALL be the first low-phase cycle.
REQ-019 SHALL sample tdo in the first high-phase cycle of each bit into rdata[bit] (SCAN and SCAN_FLIP_TMS only).
REQ-020 SHALL execute RESET as 6 TCK cycles (tms=1 for cycles 1-5, tms=0 for cycle 6), ignore nbits, hold tdi=0 and return rdata=0.
REQ-021 SHALL execute TMS_SEQ as nbits TCK cycles with tms=wdata[i], hold tdi=0 and return rdata=0.
REQ-022 SHALL execute SCAN with tdi=wdata[i] and tms=0 on all bits.
REQ-023 SHALL execute SCAN_FLIP_TMS as SCAN, except tms=1 during the last bit only.
REQ-024 SHALL clamp nbits above 32 to 32.
REQ-025 SHALL handle nbits=0 (non-RESET) with no TCK activity, done one cycle after gnt, and rdata=0.
REQ-026 SHALL, after the last high phase, enter DONE with tck=0, tms=0 and tdi=0, and pulse the granted requester's done; done SHALL fire exactly N*2*HALF_DIV cycles after gnt.
REQ-027 SHALL allow the earliest next gnt in the cycle after done.
REQ-028 SHALL hold rdata stable from done until the next done.
REQ-029 SHALL allow a requester to drop req before gnt (withdrawal) with no effect; after gnt, req is don't-care.
REQ-030 SHALL treat enable falling mid-command as having no effect on the running command; only new grants are blocked.
REQ-031 SHALL never assert both gnt outputs, or both done outputs, in the same cycle.

Reset
REQ-032 SHALL, while rst_n=0 at a clk edge, force state=IDLE, tck=0, tms=0, tdi=0, gnt*=0, done*=0, busy=0, rdata=0, and RR pointer to favour requester 0.
REQ-033 SHALL, on reset mid-RUN, drop the command with no done issued.

Configuration
REQ-034 SHALL, with JTAG_SEQ_RR_EN defined, arbitrate round-robin: when both requesters are high, the one not granted last wins, and the pointer updates on each gnt.
REQ-035 SHALL, without JTAG_SEQ_RR_EN, give req0 fixed priority over req1.

Verification
REQ-036 SHALL cover: HALF_DIV=2, req0 SCAN nbits=8 wdata=0xA5, tdo looped to tdi -> tdi bit sequence 1,0,1,0,0,1,0,1; rdata=0x000000A5; done0 exactly 32 cycles after gnt0.
REQ-037 SHALL cover: req0 RESET -> 6 tck rising edges, tms high for first 5, then 0; tdi=0; rdata=0.
REQ-038 SHALL cover: SCAN_FLIP_TMS nbits=5 wdata=0x1F, tdo=0 -> tms=1 only during 5th bit; rdata=0; tms=0 after done.
REQ-039 SHALL cover: req0 and req1 high continuously, JTAG_SEQ_RR_EN defined -> grants alternate 0,1,0,1; with the macro undefined -> only req0 is granted.
REQ-040 SHALL cover: rst_n low for 1 cycle midway through a 32-bit SCAN -> next cycle tck=tms=tdi=0, busy=0, no done; a fresh req0 is granted afterwards.
REQ-041 SHALL cover: enable=0 with req1 high -> no gnt for 100 cycles; enable=1 -> gnt1 next cycle.
